irq_arbiter: RTL and testbench

// - Multi-source interrupt controller that shares the CPU's single intReq/intAck pair between NSRC peripheral requesters.
// - Latches rising edges into pending bits, masks them, and arbitrates a winner. It raises intReq, records the serviced source in a CAUSE register on acknowledge, and waits for RETI.
// - Sits on the CPU I/O port bus. Registers are in direct-access space (0xE0..0xFF) so the ISR at address 0x001 reads CAUSE with one direct IN.

---
 rtl/irq_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_irq_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// irq_arbiter: shares one CPU intReq/intAck pair between NSRC interrupt sources.
// Rising edges on irqSrc latch into PEND; PEND & MASK is arbitrated to a winner.
// intReq is raised toward the CPU. On acknowledge the winner is recorded in CAUSE
// and its pending bit is cleared. The block then waits for RETI (intAck falling).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   irqSrc[NSRC]        peripheral request lines (synchronous to clk)
//   intReq / intAck     CPU interrupt handshake (intReq registered)
//   portAddress/Read/Write/DataIn   CPU I/O port bus
//   portDataOut         combinational read data, 0 when not selected
//   portSelect          high for a read that hits this block
//
// Register map at BASE_ADDR: +0 PEND (W1C), +1 MASK (RW), +2 CAUSE (RO).
// Build option IRQ_ARB_ROUNDROBIN_EN: the block uses rotating priority, and
// lastIdx can be read at +3. Without it, the lowest index has fixed priority.
module irq_arbiter #(
  parameter int unsigned NSRC      = 8,
  parameter logic [7:0]  BASE_ADDR = 8'hF8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irqSrc,
  output logic            intReq,
  input  logic            intAck,
  input  logic [7:0]      portAddress,
  input  logic            portRead,
  input  logic            portWrite,
  input  logic [7:0]      portDataIn,
  output logic [7:0]      portDataOut,
  output logic            portSelect
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned DW    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NSRC-1:0]   pend_q, pend_d;
  logic [NSRC-1:0]   mask_q;
  logic [DW-1:0]     cause_q, cause_d;
  logic [NSRC-1:0]   irq_prev_q;
  logic              ack_prev_q;
  logic              int_req_q, int_req_d;

  logic [NSRC-1:0]   req;
  logic [DW-1:0]     req8;
  logic              req_any;
  logic [IDX_W-1:0]  winner;
  logic              take;
  logic [NSRC-1:0]   clr_ack;
  logic [NSRC-1:0]   w1c;
  logic [NSRC-1:0]   set_edge;
  logic              ack_rise, ack_fall;

  logic              blk_hit;
  logic [1:0]        off;
  logic              rd_hit;
  logic              wr_pend, wr_mask;

`ifdef IRQ_ARB_ROUNDROBIN_EN
  logic [IDX_W-1:0]  last_idx_q;
  logic [3:0]        cand;
  logic              found;
`endif

  // Address decode; the block occupies one 4-aligned window.
  assign blk_hit = (portAddress[7:2] == BASE_ADDR[7:2]);
  assign off     = portAddress[1:0];
`ifdef IRQ_ARB_ROUNDROBIN_EN
  assign rd_hit  = blk_hit;
`else
  assign rd_hit  = blk_hit && (off != 2'd3);
`endif
  assign wr_pend = portWrite && blk_hit && (off == 2'd0);
  assign wr_mask = portWrite && blk_hit && (off == 2'd1);

  // Read mux
  always_comb begin
    portDataOut = '0;
    portSelect  = portRead && rd_hit;
    if (portSelect) begin
      case (off)
        2'd0:    portDataOut = DW'(pend_q);
        2'd1:    portDataOut = DW'(mask_q);
        2'd2:    portDataOut = cause_q;
`ifdef IRQ_ARB_ROUNDROBIN_EN
        2'd3:    portDataOut = {5'b0, last_idx_q};
`endif
        default: portDataOut = '0;
      endcase
    end
  end

  assign req      = pend_q & mask_q;
  assign req8     = DW'(req);
  assign req_any  = |req;
  assign set_edge = irqSrc & ~irq_prev_q;
  assign ack_rise = intAck && !ack_prev_q;
  assign ack_fall = !intAck && ack_prev_q;
  assign w1c      = wr_pend ? portDataIn[NSRC-1:0] : '0;

`ifdef IRQ_ARB_ROUNDROBIN_EN
  // Rotating search starting just after the last serviced source
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      cand = 4'(last_idx_q) + 4'(k) + 4'd1;
      if (cand >= 4'(NSRC)) cand = cand - 4'(NSRC);
      if (!found && req8[cand[IDX_W-1:0]]) begin
        winner = cand[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end
`else
  // Fixed priority: lowest index wins (scan downward so the last hit is lowest)
  always_comb begin
    winner = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (req8[i]) winner = IDX_W'(i);
    end
  end
`endif

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        // Late ack after a withdrawn request: serve it as spurious
        if (ack_rise) begin
          cause_d = 8'h00;
          state_d = SERVICE;
        end else if (req_any) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_rise) begin
          state_d = SERVICE;
          if (req_any) begin
            cause_d = {1'b1, 4'b0, winner};
            take    = 1'b1;
          end else begin
            cause_d = 8'h00;
          end
        end else if (!req_any) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (ack_fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // intReq follows REQ one cycle behind entry and drops on the edge that leaves REQ
    int_req_d = (state_q == REQ) && (state_d == REQ);
  end

  // Pending update; a new edge beats a same-cycle clear
  always_comb begin
    clr_ack = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      clr_ack[i] = take && (winner == IDX_W'(i));
    end
    pend_d = (pend_q & ~(w1c | clr_ack)) | set_edge;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      mask_q     <= '0;
      cause_q    <= '0;
      irq_prev_q <= '0;
      // Capture the live intAck so an ack held across reset is not seen as a new edge
      ack_prev_q <= intAck;
      int_req_q  <= 1'b0;
`ifdef IRQ_ARB_ROUNDROBIN_EN
      last_idx_q <= IDX_W'(NSRC - 1);
`endif
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cause_q    <= cause_d;
      irq_prev_q <= irqSrc;
      ack_prev_q <= intAck;
      int_req_q  <= int_req_d;
      if (wr_mask) mask_q <= portDataIn[NSRC-1:0];
`ifdef IRQ_ARB_ROUNDROBIN_EN
      if (take) last_idx_q <= winner;
`endif
    end
  end

  assign intReq = int_req_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter. Each port read pushes the expected
// {portSelect, portDataOut, intReq} for that cycle. A negedge monitor pops the
// entry and compares it whenever portRead is active.
module tb_irq_arbiter;

  localparam logic [7:0] A_PEND  = 8'hF8;
  localparam logic [7:0] A_MASK  = 8'hF9;
  localparam logic [7:0] A_CAUSE = 8'hFA;
  localparam logic [7:0] A_LAST  = 8'hFB;
  localparam logic [7:0] A_UNMAP = 8'hFD;

`ifdef IRQ_ARB_ROUNDROBIN_EN
  localparam logic [7:0] T2_FIRST  = 8'h83;
  localparam logic [7:0] T2_REM    = 8'h02;
  localparam logic [7:0] T2_SECOND = 8'h81;
  localparam logic       LAST_SEL  = 1'b1;
`else
  localparam logic [7:0] T2_FIRST  = 8'h81;
  localparam logic [7:0] T2_REM    = 8'h08;
  localparam logic [7:0] T2_SECOND = 8'h83;
  localparam logic       LAST_SEL  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irqSrc;
  logic       intReq;
  logic       intAck;
  logic [7:0] portAddress;
  logic       portRead;
  logic       portWrite;
  logic [7:0] portDataIn;
  logic [7:0] portDataOut;
  logic       portSelect;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] addr;
    logic       sel;
    logic [7:0] data;
    logic       irq;
    string      name;
  } exp_t;

  exp_t sb[$];

  irq_arbiter #(.NSRC(8), .BASE_ADDR(8'hF8)) dut (
    .clk         (clk),
    .reset       (reset),
    .irqSrc      (irqSrc),
    .intReq      (intReq),
    .intAck      (intAck),
    .portAddress (portAddress),
    .portRead    (portRead),
    .portWrite   (portWrite),
    .portDataIn  (portDataIn),
    .portDataOut (portDataOut),
    .portSelect  (portSelect)
  );

  always #5 clk = ~clk;

  // Monitor: compare every read cycle against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (portRead) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_read addr=%h got sel=%0b data=%h irq=%0b want no read",
                 portAddress, portSelect, portDataOut, intReq);
      end else begin
        e = sb.pop_front();
        if (portSelect !== e.sel || portDataOut !== e.data || intReq !== e.irq) begin
          bad++;
          $display("FAIL %s addr=%h got sel=%0b data=%h irq=%0b want sel=%0b data=%h irq=%0b",
                   e.name, e.addr, portSelect, portDataOut, intReq, e.sel, e.data, e.irq);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, input logic s, input logic [7:0] d,
                    input logic q, input string n);
    exp_t e;
    e.addr = a; e.sel = s; e.data = d; e.irq = q; e.name = n;
    sb.push_back(e);
    portAddress = a;
    portRead    = 1'b1;
    tick();
    portRead    = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    portAddress = a;
    portDataIn  = d;
    portWrite   = 1'b1;
    tick();
    portWrite   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; irqSrc = '0; intAck = 1'b0;
    portAddress = '0; portRead = 1'b0; portWrite = 1'b0; portDataIn = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset values
    rd(A_PEND,  1'b1, 8'h00, 1'b0, "rst_pend");
    rd(A_MASK,  1'b1, 8'h00, 1'b0, "rst_mask");
    rd(A_CAUSE, 1'b1, 8'h00, 1'b0, "rst_cause");

    // Test 1: single source latency and ack
    wr(A_MASK, 8'h05);
    irqSrc = 8'h04; tick(); irqSrc = 8'h00;
    rd(A_PEND,  1'b1, 8'h04, 1'b0, "t1_lat1");
    rd(A_PEND,  1'b1, 8'h04, 1'b0, "t1_lat2");
    rd(A_CAUSE, 1'b1, 8'h00, 1'b1, "t1_lat3_irq");
    intAck = 1'b1;
    rd(A_CAUSE, 1'b1, 8'h00, 1'b1, "t1_ack_cycle");
    rd(A_CAUSE, 1'b1, 8'h82, 1'b0, "t1_cause");
    rd(A_PEND,  1'b1, 8'h00, 1'b0, "t1_pend_clr");
    intAck = 1'b0; tick();
    rd(A_PEND,  1'b1, 8'h00, 1'b0, "t1_idle");

    // Test 2: two sources, arbitration order and back-to-back re-raise
    wr(A_MASK, 8'hFF);
    irqSrc = 8'h0A; tick(); irqSrc = 8'h00;
    tick(); tick();
    rd(A_CAUSE, 1'b1, 8'h82, 1'b1, "t2_cause_hold");
    intAck = 1'b1; tick();
    rd(A_CAUSE, 1'b1, T2_FIRST, 1'b0, "t2_first");
    rd(A_PEND,  1'b1, T2_REM,   1'b0, "t2_remaining");
    intAck = 1'b0; tick();
    rd(A_PEND,  1'b1, T2_REM,   1'b0, "t2_b2b_1");
    rd(A_PEND,  1'b1, T2_REM,   1'b0, "t2_b2b_2");
    rd(A_PEND,  1'b1, T2_REM,   1'b1, "t2_b2b_irq");
    intAck = 1'b1; tick();
    rd(A_CAUSE, 1'b1, T2_SECOND, 1'b0, "t2_second");
    intAck = 1'b0; tick();
    rd(A_PEND,  1'b1, 8'h00, 1'b0, "t2_empty");

    // Test 3: masked source pends without request, unmask raises it
    wr(A_MASK, 8'hEF);
    irqSrc = 8'h10; tick(); irqSrc = 8'h00;
    rd(A_PEND,  1'b1, 8'h10, 1'b0, "t3_masked1");
    rd(A_PEND,  1'b1, 8'h10, 1'b0, "t3_masked2");
    rd(A_PEND,  1'b1, 8'h10, 1'b0, "t3_masked3");
    wr(A_MASK, 8'h10);
    rd(A_MASK,  1'b1, 8'h10, 1'b0, "t3_unmask1");
    rd(A_PEND,  1'b1, 8'h10, 1'b0, "t3_unmask2");
    rd(A_PEND,  1'b1, 8'h10, 1'b1, "t3_irq");

    // Test 4: withdrawal by W1C, then spurious ack
    wr(A_PEND, 8'h10);
    rd(A_PEND,  1'b1, 8'h00, 1'b1, "t4_w1c_irq_still");
    rd(A_PEND,  1'b1, 8'h00, 1'b0, "t4_withdrawn");
    intAck = 1'b1; tick();
    rd(A_CAUSE, 1'b1, 8'h00, 1'b0, "t4_spurious_cause");
    wr(A_MASK, 8'h01);
    irqSrc = 8'h01; tick(); irqSrc = 8'h00;
    rd(A_PEND,  1'b1, 8'h01, 1'b0, "t4_service_hold1");
    rd(A_PEND,  1'b1, 8'h01, 1'b0, "t4_service_hold2");
    intAck = 1'b0; tick();
    rd(A_PEND,  1'b1, 8'h01, 1'b0, "t4_reti1");
    rd(A_PEND,  1'b1, 8'h01, 1'b0, "t4_reti2");
    rd(A_PEND,  1'b1, 8'h01, 1'b1, "t4_reti_irq");
    intAck = 1'b1; tick();
    rd(A_CAUSE, 1'b1, 8'h80, 1'b0, "t4_cause_src0");
    intAck = 1'b0; tick();

    // Test 5: set beats same-cycle W1C; unmapped reads
    wr(A_MASK, 8'h00);
    irqSrc = 8'h01;
    wr(A_PEND, 8'h01);
    irqSrc = 8'h00;
    rd(A_PEND,  1'b1, 8'h01, 1'b0, "t5_set_wins");
    rd(A_UNMAP, 1'b0, 8'h00, 1'b0, "t5_unmapped");
    rd(A_LAST,  LAST_SEL, 8'h00, 1'b0, "t5_plus3");
    wr(A_PEND, 8'h01);
    rd(A_PEND,  1'b1, 8'h00, 1'b0, "t5_w1c");

    // Test 6: reset during SERVICE with intAck held high
    wr(A_MASK, 8'h01);
    irqSrc = 8'h01; tick(); irqSrc = 8'h00;
    tick(); tick();
    intAck = 1'b1; tick();
    rd(A_CAUSE, 1'b1, 8'h80, 1'b0, "t6_pre_reset");
    reset = 1'b1; tick(); reset = 1'b0;
    rd(A_CAUSE, 1'b1, 8'h00, 1'b0, "t6_rst_cause");
    rd(A_MASK,  1'b1, 8'h00, 1'b0, "t6_rst_mask");
    rd(A_PEND,  1'b1, 8'h00, 1'b0, "t6_rst_pend");
    wr(A_MASK, 8'h01);
    irqSrc = 8'h01; tick(); irqSrc = 8'h00;
    rd(A_PEND,  1'b1, 8'h01, 1'b0, "t6_req1");
    rd(A_PEND,  1'b1, 8'h01, 1'b0, "t6_req2");
    rd(A_CAUSE, 1'b1, 8'h00, 1'b1, "t6_no_spurious");
    intAck = 1'b0; tick();
    rd(A_CAUSE, 1'b1, 8'h00, 1'b1, "t6_ack_low");
    intAck = 1'b1; tick();
    rd(A_CAUSE, 1'b1, 8'h80, 1'b0, "t6_real_ack");
    intAck = 1'b0; tick();
    rd(A_PEND,  1'b1, 8'h00, 1'b0, "t6_final");

    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d entries left want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
